// File: rtl/cpu_pkg.sv
// Shared CPU types and constants.
// Used by the fetch queue and its storage array.
package cpu_pkg;

  localparam int WORD_W   = 32;
  localparam int FQ_DEPTH = 4;

  localparam logic [WORD_W-1:0] BUBBLE_INSTR = 32'h0;

  typedef struct packed {
    logic [WORD_W-1:0] pc;
    logic [WORD_W-1:0] instr;
  } fq_entry_t;

endpackage

// File: rtl/fq_storage.sv
// Fetch queue entry array.
// One synchronous write port, one async read port, no reset.
module fq_storage
  import cpu_pkg::*;
#(
  parameter int DEPTH = FQ_DEPTH,
  parameter int WIDTH = WORD_W,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               we,
  input  logic [AW-1:0]      waddr,
  input  logic [2*WIDTH-1:0] wdata,
  input  logic [AW-1:0]      raddr,
  output logic [2*WIDTH-1:0] rdata
);

  logic [2*WIDTH-1:0] mem [DEPTH];

  // write the pushed {pc, instr} pair
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fetch_queue.sv
// Instruction prefetch queue between IF and ID.
// Decouples fetch from decode stalls; flushed on taken branch.
module fetch_queue
  import cpu_pkg::*;
#(
  parameter int DEPTH = FQ_DEPTH,
  parameter int WIDTH = WORD_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_valid,
  input  logic [WIDTH-1:0]         in_pc,
  input  logic [WIDTH-1:0]         in_instr,
  output logic                     in_ready,
  output logic                     out_valid,
  output logic [WIDTH-1:0]         out_pc,
  output logic [WIDTH-1:0]         out_instr,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic [CW-1:0]      count;
  logic               push;
  logic               pop;
  logic [2*WIDTH-1:0] rd_data;

  assign in_ready  = (count != CW'(DEPTH));
  assign out_valid = (count != '0);
  assign push      = in_valid & in_ready & ~flush;
  assign pop       = out_valid & out_ready & ~flush;
  assign occupancy = count;

  fq_storage #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH),
    .AW    (AW)
  ) u_storage (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr),
    .wdata ({in_pc, in_instr}),
    .raddr (rd_ptr),
    .rdata (rd_data)
  );

  // pointers and count; flush wins over push/pop
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // head entry, or a bubble when empty
  always_comb begin
    out_pc    = '0;
    out_instr = WIDTH'(BUBBLE_INSTR);
    if (out_valid) begin
      out_pc    = rd_data[2*WIDTH-1:WIDTH];
      out_instr = rd_data[WIDTH-1:0];
    end
  end

  a_count_max: assert property (
    @(posedge clk) disable iff (!rst)
    count <= CW'(DEPTH)
  );

  a_valid_cnt: assert property (
    @(posedge clk) disable iff (!rst)
    out_valid == (count != '0)
  );

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue.
// Queue-based scoreboard checked on every falling edge.
module tb_fetch_queue;
  import cpu_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic              flush;
  logic              in_valid;
  logic [WORD_W-1:0] in_pc;
  logic [WORD_W-1:0] in_instr;
  logic              in_ready;
  logic              out_valid;
  logic [WORD_W-1:0] out_pc;
  logic [WORD_W-1:0] out_instr;
  logic              out_ready;
  logic [2:0]        occupancy;

  int n_checks = 0;
  int n_errors = 0;

  fq_entry_t exp_q[$];

  fetch_queue dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_pc     (in_pc),
    .in_instr  (in_instr),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_pc    (out_pc),
    .out_instr (out_instr),
    .out_ready (out_ready),
    .occupancy (occupancy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // scoreboard: predict outputs, then apply this cycle's push/pop
  always @(negedge clk) begin
    int sz;
    if (!rst) begin
      check("rst_in_ready", in_ready, 1'b1);
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_out_instr", out_instr, 0);
      check("rst_occupancy", occupancy, 0);
      exp_q.delete();
    end else begin
      sz = exp_q.size();
      check("in_ready", in_ready, sz != 4);
      check("out_valid", out_valid, sz != 0);
      check("occupancy", occupancy, sz);
      if (sz != 0) begin
        check("out_pc", out_pc, exp_q[0].pc);
        check("out_instr", out_instr, exp_q[0].instr);
      end else begin
        check("bubble_pc", out_pc, 0);
        check("bubble_instr", out_instr, 0);
      end
      if (flush) begin
        exp_q.delete();
      end else begin
        if (out_ready && sz != 0) void'(exp_q.pop_front());
        if (in_valid && sz != 4) exp_q.push_back('{pc: in_pc, instr: in_instr});
      end
    end
  end

  task automatic drain();
    int budget;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    budget = 0;
    while (exp_q.size() != 0 && budget < 20) begin
      tick();
      budget++;
    end
    check("drain_done", exp_q.size(), 0);
  endtask

  initial begin
    rst       = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b1;
    in_pc     = 32'h100;
    in_instr  = 32'hDEAD;
    out_ready = 1'b0;
    tick();
    tick();
    check("t1_in_ready", in_ready, 1'b1);
    check("t1_out_valid", out_valid, 1'b0);
    rst      = 1'b1;
    in_valid = 1'b0;
    tick();
    check("t1_occ_after", occupancy, 0);

    // fill with 5 attempts, 5th must be dropped
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_pc    = 32'(4 * (i + 1));
      in_instr = 32'hA0 + 32'(i);
      tick();
    end
    in_valid = 1'b0;
    check("t2_occ_full", occupancy, 4);
    check("t2_in_ready", in_ready, 1'b0);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("t2_order_pc", out_pc, 32'(4 * (i + 1)));
      check("t2_order_instr", out_instr, 32'hA0 + 32'(i));
      tick();
    end
    check("t2_empty", out_valid, 1'b0);

    // streaming
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      in_pc    = 32'h200 + 32'(4 * i);
      in_instr = 32'hB0 + 32'(i);
      tick();
      check("t3_occ", occupancy, 1);
      check("t3_instr", out_instr, 32'hB0 + 32'(i));
    end
    drain();

    // wrap-around with stalls
    for (int i = 0; i < 16; i++) begin
      in_valid  = (i % 3) != 2;
      out_ready = (i % 4) == 1 || (i % 4) == 2;
      in_pc     = 32'h300 + 32'(4 * i);
      in_instr  = 32'hC0 + 32'(i);
      tick();
    end
    drain();

    // flush with 3 entries queued
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_pc    = 32'h400 + 32'(4 * i);
      in_instr = 32'hD0 + 32'(i);
      tick();
    end
    flush     = 1'b1;
    in_valid  = 1'b1;
    in_pc     = 32'h4FC;
    in_instr  = 32'hDF;
    out_ready = 1'b1;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    check("t5_occ", occupancy, 0);
    check("t5_valid", out_valid, 1'b0);
    in_valid = 1'b1;
    in_pc    = 32'h500;
    in_instr = 32'hE0;
    tick();
    in_valid = 1'b0;
    check("t5_next_valid", out_valid, 1'b1);
    check("t5_next_instr", out_instr, 32'hE0);
    drain();

    // async reset mid-stream
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      in_pc    = 32'h600 + 32'(4 * i);
      in_instr = 32'hF0 + 32'(i);
      tick();
    end
    in_valid = 1'b0;
    check("t6_pre_occ", occupancy, 2);
    #2;
    rst = 1'b0;
    #1;
    check("t6_async_valid", out_valid, 1'b0);
    check("t6_async_occ", occupancy, 0);
    tick();
    rst = 1'b1;
    tick();
    in_valid = 1'b1;
    in_pc    = 32'h700;
    in_instr = 32'hF8;
    tick();
    in_valid = 1'b0;
    check("t6_occ_one", occupancy, 1);
    check("t6_instr", out_instr, 32'hF8);
    drain();

    tick();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
